rni_txlink_arb: RTL and testbench
=================================

# rni_txlink_arb

Transmit-side link controller for one RNI CHI outbound channel (e.g. TXREQ/TXDAT). It shares the single channel between `NUM_REQ` internal requesters using round-robin, gates every flit on an available link credit, and sequences the TXACTIVEREQ/TXACTIVEACK link handshake. On link deactivation it returns all unspent credits with L-credit return flits. It sits between the RNI request/data queues and the CHI TX pins.

## Interface
- `NUM_REQ`, 4: number of requesters; range 2..8.
- `FLIT_W`, 128: flit width in bits.
- `LCRD_MAX`, 15: maximum credits held; range 1..15.

- `clk`  in  1  clock.
- `rst`  in  1  asynchronous reset, active-low.
- `link_en`  in  1  level request to bring the link up (1) or take it down (0).
- `req_valid`  in  NUM_REQ  requester i has a flit.
- `req_flit`  in  NUM_REQ*FLIT_W  flit of requester i at bits [i*FLIT_W +: FLIT_W].
- `req_ready`  out  NUM_REQ  one-hot accept; transfer occurs when `req_valid[i] & req_ready[i]`.
- `txlcrdv`  in  1  one link credit received this cycle.
- `txactiveack`  in  1  receiver activation acknowledge.
- `txactivereq`  out  1  link activation request.
- `txflitpend`  out  1  flit-pending indication.
- `txflitv`  out  1  flit valid.
- `txflit`  out  FLIT_W  flit payload.
- `link_up`  out  1  state is RUN.
- `lcrd_ovf`  out  1  sticky error: credit received while counter at `LCRD_MAX`.

## Operation
- FSM states: STOP, ACT, RUN, DEACT. Reset state STOP.
  - STOP: `txactivereq`=0. Goes to ACT when `link_en`=1 and `txactiveack`=0.
  - ACT: `txactivereq`=1. Goes to RUN when `txactiveack`=1. If `link_en` drops while in ACT, stays until ack, then goes to DEACT.
  - RUN: `txactivereq`=1; arbitration is enabled. Goes to DEACT when `link_en`=0.
  - DEACT: `txactivereq`=0, no requester grants. Each cycle with credit count ≠ 0 sends one return flit (`txflitv`=1, `txflit`=all zeros, i.e. opcode LCrdReturn) and decrements the count. Goes to STOP when count==0, no return flit is in flight, and `txactiveack`=0.
- Credit counter: width `$clog2(LCRD_MAX+1)`, reset 0.
  - Increments on `txlcrdv` in ACT, RUN or DEACT; `txlcrdv` in STOP is ignored.
  - Decrements on each requester transfer or return flit.
  - When increment and decrement coincide, the count holds.
  - A `txlcrdv` at `LCRD_MAX` without a decrement saturates the count and sets `lcrd_ovf`. Only reset clears `lcrd_ovf`.
- Arbitration:
  - `req_ready[i]`=1 only in RUN with count ≠ 0, for the first valid requester searching upward from `rr_ptr+1` modulo `NUM_REQ`.
  - `rr_ptr` (reset `NUM_REQ-1`) loads the granted index only on a transfer.
  - `req_ready` is combinational from `req_valid`, state and count. It never depends on incoming `txlcrdv` in the same cycle.
- `txflitpend`=1 in RUN and DEACT, 0 otherwise.

## Timing
- Reset values: `txactivereq`, `txflitpend`, `txflitv`, `link_up`, `lcrd_ovf` = 0; `txflit` = 0; count = 0; `req_ready` = 0.
- A requester transfer in cycle N produces a registered `txflitv`=1 with the captured flit in cycle N+1. Throughput is one flit per cycle while credits last.
- A credit on `txlcrdv` in cycle N is usable for a grant in cycle N+1.
- The RUN to DEACT transition takes effect the cycle after `link_en` is sampled low. A transfer accepted in the last RUN cycle still emits its flit.
- Return flits are registered like normal flits, one cycle after the decrement.
- Reset asserted mid-operation clears everything immediately, with no return flits. Credits held at that point are lost by design.

## Structure
- Shared package `rni_link_pkg`:
  - FSM state encoding (`LINK_STOP`, `LINK_ACT`, `LINK_RUN`, `LINK_DEACT`).
  - `LCRD_RETURN_FLIT` constant (all zeros).
  - Credit-width function.
- Sub-module `rni_rr_arb`: parameterised round-robin arbiter producing a one-hot grant from a request vector, an enable and a pointer-update strobe.
- The credit counter, FSM and flit output register live in the top module.

## Test plan
- Bring-up: `link_en`=1; ack returned 3 cycles after `txactivereq` rises → ACT held 3 cycles, then RUN, `link_up`=1, `txflitpend`=1.
- Credit gating: 2 credits, all 4 requesters valid → grants to req0 then req1. No further grant until `txlcrdv`; the next grant goes to req2 the cycle after the credit.
- Fairness: 8 credits, req1 and req3 continuously valid → grants alternate 1, 3, 1, 3; `txflit` matches each source one cycle after its transfer.
- Simultaneous: `txlcrdv` and a transfer in the same cycle with count=1 → count stays 1; a grant is available in the next cycle.
- Deactivation: RUN with count=5, `link_en`→0 → `txactivereq` falls; exactly 5 all-zero flits on consecutive cycles; STOP after `txactiveack`=0.
- Overflow and reset: count=15 (`LCRD_MAX`) plus `txlcrdv` → count stays 15 and `lcrd_ovf`=1. Asserting `rst` low mid-stream → all outputs 0 at once and `lcrd_ovf` cleared.

Source files
------------

// File: rtl/rni_txlink_arb_pkg.sv
// ---------------------------------------------------------------------------
// rni_link_pkg
// Shared definitions for the RNI transmit link controller.
// Contents:
//   link_state_e      - link FSM state encoding (STOP/ACT/RUN/DEACT)
//   LCRD_RETURN_FLIT  - all-zero flit (opcode LCrdReturn), sliced to FLIT_W
//   lcrd_cnt_width()  - width of a counter that holds 0..lcrd_max
// ---------------------------------------------------------------------------
package rni_link_pkg;

    typedef enum logic [1:0] {
        LINK_STOP  = 2'd0,
        LINK_ACT   = 2'd1,
        LINK_RUN   = 2'd2,
        LINK_DEACT = 2'd3
    } link_state_e;

    // Sized generously so any supported flit width can slice its low bits.
    localparam int unsigned MAX_FLIT_W = 1024;
    localparam logic [MAX_FLIT_W-1:0] LCRD_RETURN_FLIT = '0;

    function automatic int unsigned lcrd_cnt_width(input int unsigned lcrd_max);
        return $clog2(lcrd_max + 1);
    endfunction

endpackage

// File: rtl/rni_txlink_arb_if.sv
// ---------------------------------------------------------------------------
// rni_txlink_arb_if
// Bundles the requester side and the CHI TX pin side of the link controller.
// Modports:
//   master - the environment: drives link_en, requester valid/flit, credits
//            and activation acknowledge; observes everything else.
//   slave  - the link controller itself.
// Signals:
//   link_en, req_valid[NUM_REQ], req_flit[NUM_REQ*FLIT_W], req_ready[NUM_REQ],
//   txlcrdv, txactiveack, txactivereq, txflitpend, txflitv, txflit[FLIT_W],
//   link_up, lcrd_ovf
// ---------------------------------------------------------------------------
interface rni_txlink_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int FLIT_W  = 128
);

    logic                      link_en;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*FLIT_W-1:0] req_flit;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      txlcrdv;
    logic                      txactiveack;
    logic                      txactivereq;
    logic                      txflitpend;
    logic                      txflitv;
    logic [FLIT_W-1:0]         txflit;
    logic                      link_up;
    logic                      lcrd_ovf;

    modport master (
        output link_en, req_valid, req_flit, txlcrdv, txactiveack,
        input  req_ready, txactivereq, txflitpend, txflitv, txflit, link_up, lcrd_ovf
    );

    modport slave (
        input  link_en, req_valid, req_flit, txlcrdv, txactiveack,
        output req_ready, txactivereq, txflitpend, txflitv, txflit, link_up, lcrd_ovf
    );

endinterface

// File: rtl/rni_txlink_arb_rr_arb.sv
// ---------------------------------------------------------------------------
// rni_rr_arb
// Round-robin arbiter. Searches upward from ptr+1 (mod NUM_REQ) for the first
// asserted request and issues a one-hot grant while en_i is high. The pointer
// only advances to the granted index when upd_i reports an actual transfer,
// so a grant that is not taken does not cost the requester its turn.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   req_i        - request vector
//   en_i         - grant enable
//   upd_i        - pointer update strobe (transfer happened this cycle)
//   gnt_o        - one-hot grant
//   gnt_idx_o    - binary index of the grant (pointer value when no grant)
// ---------------------------------------------------------------------------
module rni_rr_arb #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic                       en_i,
    input  logic                       upd_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Rotating priority search; k runs 1..NUM_REQ so the last-served
    // requester is considered last.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = ptr_q;
        found     = 1'b0;
        cand      = '0;
        if (en_i) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
                if (!found && req_i[cand]) begin
                    found       = 1'b1;
                    gnt_o[cand] = 1'b1;
                    gnt_idx_o   = cand;
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (upd_i) begin
            ptr_d = gnt_idx_o;
        end
    end

    // Pointer starts at the top index so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rni_txlink_arb.sv
// ---------------------------------------------------------------------------
// rni_txlink_arb
// Transmit-side link controller for one RNI CHI outbound channel. Shares the
// channel between NUM_REQ requesters round-robin, spends one link credit per
// flit, runs the TXACTIVEREQ/TXACTIVEACK handshake and, on deactivation,
// hands back every unspent credit as an all-zero LCrdReturn flit.
// Ports:
//   clk      - clock
//   rst_n    - asynchronous active-low reset (clears everything, credits lost)
//   link_if  - slave modport of rni_txlink_arb_if (requesters + TX pins)
// Parameters:
//   NUM_REQ (2..8), FLIT_W, LCRD_MAX (1..15)
// ---------------------------------------------------------------------------
module rni_txlink_arb
    import rni_link_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int FLIT_W   = 128,
    parameter int LCRD_MAX = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    rni_txlink_arb_if.slave link_if
);

    localparam int CNT_W = lcrd_cnt_width(LCRD_MAX);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LCRD_MAX);

    link_state_e       state_q;
    link_state_e       state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              flitv_q;
    logic              flitv_d;
    logic [FLIT_W-1:0] flit_q;
    logic [FLIT_W-1:0] flit_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               arb_en;
    logic               xfer;
    logic               ret_flit;
    logic               lcrd_inc;
    logic               cnt_dec;
    logic [FLIT_W-1:0]  sel_flit;

    // Grants depend only on registered state/count and req_valid, never on
    // a credit arriving this cycle, so req_ready has no path from txlcrdv.
    assign arb_en   = (state_q == LINK_RUN) && (cnt_q != '0);
    assign xfer     = |(link_if.req_valid & gnt);
    assign ret_flit = (state_q == LINK_DEACT) && (cnt_q != '0);
    assign lcrd_inc = link_if.txlcrdv && (state_q != LINK_STOP);
    assign cnt_dec  = xfer || ret_flit;
    assign sel_flit = link_if.req_flit[int'(gnt_idx)*FLIT_W +: FLIT_W];

    rni_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (link_if.req_valid),
        .en_i      (arb_en),
        .upd_i     (xfer),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    // Link FSM. A link_en drop during ACT is honoured only after the ack, so
    // the receiver always sees a complete activate/deactivate pair. DEACT is
    // left once all credits are returned, the last flit has left the output
    // register and the receiver has dropped its ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LINK_STOP: begin
                if (link_if.link_en && !link_if.txactiveack) begin
                    state_d = LINK_ACT;
                end
            end
            LINK_ACT: begin
                if (link_if.txactiveack) begin
                    state_d = link_if.link_en ? LINK_RUN : LINK_DEACT;
                end
            end
            LINK_RUN: begin
                if (!link_if.link_en) begin
                    state_d = LINK_DEACT;
                end
            end
            LINK_DEACT: begin
                if ((cnt_q == '0) && !flitv_q && !link_if.txactiveack) begin
                    state_d = LINK_STOP;
                end
            end
            default: state_d = LINK_STOP;
        endcase
    end

    // Credit counter. A simultaneous credit and spend cancel out; a credit
    // with nothing spent at LCRD_MAX saturates and raises the sticky error.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (lcrd_inc && !cnt_dec) begin
            if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (cnt_dec && !lcrd_inc) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Output flit register: a requester flit or a credit-return flit, both
    // emitted the cycle after their credit is spent.
    always_comb begin
        flitv_d = xfer || ret_flit;
        flit_d  = LCRD_RETURN_FLIT[FLIT_W-1:0];
        if (xfer) begin
            flit_d = sel_flit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LINK_STOP;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            flitv_q <= 1'b0;
            flit_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            flitv_q <= flitv_d;
            flit_q  <= flit_d;
        end
    end

    assign link_if.req_ready   = gnt;
    assign link_if.txactivereq = (state_q == LINK_ACT) || (state_q == LINK_RUN);
    assign link_if.txflitpend  = (state_q == LINK_RUN) || (state_q == LINK_DEACT);
    assign link_if.link_up     = (state_q == LINK_RUN);
    assign link_if.txflitv     = flitv_q;
    assign link_if.txflit      = flit_q;
    assign link_if.lcrd_ovf    = ovf_q;

endmodule

// File: tb/tb_rni_txlink_arb.sv
// ---------------------------------------------------------------------------
// tb_rni_txlink_arb
// Directed bench for rni_txlink_arb: reset, bring-up, credit gating,
// round-robin fairness, coincident credit/spend, deactivation with credit
// return, STOP credit filtering, overflow saturation and mid-stream reset.
// ---------------------------------------------------------------------------
module tb_rni_txlink_arb;

    localparam int NUM_REQ  = 4;
    localparam int FLIT_W   = 128;
    localparam int LCRD_MAX = 15;

    logic clk;
    logic rst_n;
    int   nAsserts;
    int   nFails;
    int   expIdx[4];

    rni_txlink_arb_if #(.NUM_REQ(NUM_REQ), .FLIT_W(FLIT_W)) link_if ();

    rni_txlink_arb #(
        .NUM_REQ  (NUM_REQ),
        .FLIT_W   (FLIT_W),
        .LCRD_MAX (LCRD_MAX)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .link_if (link_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [FLIT_W-1:0] flitOf(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(i);
        return {w, w, w, w};
    endfunction

    // Advance past the next rising edge; registered outputs are stable here.
    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic linkEn, input logic [NUM_REQ-1:0] valid,
                                 input logic lcrdv, input logic ack);
        link_if.link_en     = linkEn;
        link_if.req_valid   = valid;
        link_if.txlcrdv     = lcrdv;
        link_if.txactiveack = ack;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [FLIT_W-1:0] observed,
                               input logic [FLIT_W-1:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string phase);
        checkOutput({phase, "_txactivereq"}, FLIT_W'(link_if.txactivereq), '0);
        checkOutput({phase, "_txflitpend"},  FLIT_W'(link_if.txflitpend),  '0);
        checkOutput({phase, "_txflitv"},     FLIT_W'(link_if.txflitv),     '0);
        checkOutput({phase, "_link_up"},     FLIT_W'(link_if.link_up),     '0);
        checkOutput({phase, "_lcrd_ovf"},    FLIT_W'(link_if.lcrd_ovf),    '0);
        checkOutput({phase, "_txflit"},      link_if.txflit,               '0);
        checkOutput({phase, "_req_ready"},   FLIT_W'(link_if.req_ready),   '0);
    endtask

    initial begin
        nAsserts = 0;
        nFails   = 0;
        rst_n    = 1'b0;
        link_if.link_en     = 1'b0;
        link_if.req_valid   = '0;
        link_if.txlcrdv     = 1'b0;
        link_if.txactiveack = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            link_if.req_flit[i*FLIT_W +: FLIT_W] = flitOf(i);
        end

        // Reset state
        repeat (2) cycle();
        checkAllZero("reset");
        rst_n = 1'b1;

        // Bring-up: ACT for three cycles, ack, then RUN
        $display("[TB] bring-up");
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
        cycle();
        checkOutput("act1_txactivereq", FLIT_W'(link_if.txactivereq), 1);
        checkOutput("act1_txflitpend",  FLIT_W'(link_if.txflitpend),  0);
        checkOutput("act1_link_up",     FLIT_W'(link_if.link_up),     0);
        cycle();
        checkOutput("act2_link_up", FLIT_W'(link_if.link_up), 0);
        cycle();
        checkOutput("act3_link_up", FLIT_W'(link_if.link_up), 0);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
        cycle();
        checkOutput("run_link_up",     FLIT_W'(link_if.link_up),     1);
        checkOutput("run_txflitpend",  FLIT_W'(link_if.txflitpend),  1);
        checkOutput("run_txactivereq", FLIT_W'(link_if.txactivereq), 1);

        // Credit gating: no grant with zero credits, then load two
        $display("[TB] credit gating");
        applyStimulus(1'b1, 4'b1111, 1'b0, 1'b1);
        checkOutput("gate_zero_cnt", FLIT_W'(link_if.req_ready), 0);
        applyStimulus(1'b1, 4'b0000, 1'b1, 1'b1);
        repeat (2) cycle();
        applyStimulus(1'b1, 4'b1111, 1'b0, 1'b1);
        checkOutput("gnt_req0", FLIT_W'(link_if.req_ready), 4'b0001);
        cycle();
        checkOutput("flit_req0_v", FLIT_W'(link_if.txflitv), 1);
        checkOutput("flit_req0",   link_if.txflit, flitOf(0));
        checkOutput("gnt_req1",    FLIT_W'(link_if.req_ready), 4'b0010);
        cycle();
        checkOutput("flit_req1",      link_if.txflit, flitOf(1));
        checkOutput("gate_no_credit", FLIT_W'(link_if.req_ready), 0);
        applyStimulus(1'b1, 4'b1111, 1'b1, 1'b1);
        checkOutput("ready_ignores_lcrdv", FLIT_W'(link_if.req_ready), 0);
        cycle();
        checkOutput("idle_txflitv", FLIT_W'(link_if.txflitv), 0);
        checkOutput("gnt_req2_after_credit", FLIT_W'(link_if.req_ready), 4'b0100);

        // Simultaneous credit and transfer at count 1 (txlcrdv still high)
        $display("[TB] simultaneous credit and spend");
        cycle();
        checkOutput("flit_req2",      link_if.txflit, flitOf(2));
        checkOutput("simul_cnt_held", FLIT_W'(link_if.req_ready), 4'b1000);
        applyStimulus(1'b1, 4'b1111, 1'b0, 1'b1);
        cycle();
        checkOutput("flit_req3",     link_if.txflit, flitOf(3));
        checkOutput("simul_cnt_one", FLIT_W'(link_if.req_ready), 0);

        // Fairness: eight credits, req1 and req3 contending
        $display("[TB] fairness");
        applyStimulus(1'b1, 4'b0000, 1'b1, 1'b1);
        repeat (8) cycle();
        applyStimulus(1'b1, 4'b1010, 1'b0, 1'b1);
        expIdx = '{1, 3, 1, 3};
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("fair_gnt%0d", i), FLIT_W'(link_if.req_ready),
                        FLIT_W'(1) << expIdx[i]);
            cycle();
            checkOutput($sformatf("fair_v%0d", i), FLIT_W'(link_if.txflitv), 1);
            checkOutput($sformatf("fair_flit%0d", i), link_if.txflit, flitOf(expIdx[i]));
        end

        // Deactivation: top up to 5 credits, drop link_en
        $display("[TB] deactivation");
        applyStimulus(1'b1, 4'b0000, 1'b1, 1'b1);
        cycle();
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
        cycle();
        checkOutput("deact_txactivereq", FLIT_W'(link_if.txactivereq), 0);
        checkOutput("deact_link_up",     FLIT_W'(link_if.link_up),     0);
        checkOutput("deact_txflitpend",  FLIT_W'(link_if.txflitpend),  1);
        checkOutput("deact_first_v",     FLIT_W'(link_if.txflitv),     0);
        applyStimulus(1'b0, 4'b1111, 1'b0, 1'b1);
        checkOutput("deact_no_grant", FLIT_W'(link_if.req_ready), 0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            checkOutput($sformatf("ret_v%0d", i),    FLIT_W'(link_if.txflitv), 1);
            checkOutput($sformatf("ret_flit%0d", i), link_if.txflit, '0);
        end
        cycle();
        checkOutput("ret_done_v",       FLIT_W'(link_if.txflitv),    0);
        checkOutput("deact_wait_ack",   FLIT_W'(link_if.txflitpend), 1);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
        cycle();
        checkOutput("stop_txflitpend",  FLIT_W'(link_if.txflitpend),  0);
        checkOutput("stop_txactivereq", FLIT_W'(link_if.txactivereq), 0);

        // Credits offered in STOP must not count
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
        repeat (2) cycle();
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
        cycle();
        checkOutput("rerun_link_up", FLIT_W'(link_if.link_up), 1);
        applyStimulus(1'b1, 4'b0001, 1'b0, 1'b1);
        checkOutput("stop_lcrd_ignored", FLIT_W'(link_if.req_ready), 0);

        // Overflow: 15 credits fill, 16th saturates and sets the flag
        $display("[TB] overflow");
        applyStimulus(1'b1, 4'b0000, 1'b1, 1'b1);
        repeat (15) cycle();
        checkOutput("ovf_before", FLIT_W'(link_if.lcrd_ovf), 0);
        cycle();
        checkOutput("ovf_set", FLIT_W'(link_if.lcrd_ovf), 1);
        applyStimulus(1'b1, 4'b0001, 1'b0, 1'b1);
        for (int i = 0; i < LCRD_MAX; i++) begin
            checkOutput($sformatf("drain%0d", i), FLIT_W'(link_if.req_ready), 4'b0001);
            cycle();
        end
        checkOutput("ovf_cnt_sat",    FLIT_W'(link_if.req_ready), 0);
        checkOutput("ovf_sticky",     FLIT_W'(link_if.lcrd_ovf),  1);

        // Mid-stream reset
        $display("[TB] mid-stream reset");
        applyStimulus(1'b1, 4'b0001, 1'b1, 1'b1);
        cycle();
        checkOutput("pre_rst_ready", FLIT_W'(link_if.req_ready), 4'b0001);
        cycle();
        checkOutput("pre_rst_txflitv", FLIT_W'(link_if.txflitv), 1);
        rst_n = 1'b0;
        #1;
        checkAllZero("midrst");
        cycle();
        checkAllZero("midrst_hold");

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
